// File: rtl/eeprom_arb.sv
// Two-requester round-robin arbiter in front of a serial EEPROM engine.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with a WAIT timeout abort.
module eeprom_arb #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [10:0] ADDR0,
    input  logic [10:0] ADDR1,
    input  logic [7:0]  WDATA0,
    input  logic [7:0]  WDATA1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [7:0]  RDATA,
    output logic        E_WR,
    output logic        E_RD,
    output logic [10:0] E_ADDR,
    inout  wire  [7:0]  E_DATA,
    input  logic        E_ACK
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [10:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            gnt_q, gnt_d;
    logic            ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;

    logic pick;
    logic busy;

    // Pointer only matters on contention; a lone requester always wins.
    assign pick = (REQ0 && REQ1) ? ptr_q : REQ1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (REQ0 || REQ1) begin
                    gnt_d   = pick;
                    we_d    = pick ? WE1 : WE0;
                    addr_d  = pick ? ADDR1 : ADDR0;
                    wdata_d = pick ? WDATA1 : WDATA0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // Acknowledge takes precedence over a simultaneous timeout.
                if (E_ACK) begin
                    if (!we_q) begin
                        rdata_d = E_DATA;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                ptr_d   = ~gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q == StIssue) || (state_q == StWait);
    assign E_WR   = busy && we_q;
    assign E_RD   = busy && !we_q;
    assign E_ADDR = addr_q;
    assign E_DATA = (busy && we_q) ? wdata_q : 8'hzz;

    assign DONE0 = (state_q == StDone) && !gnt_q;
    assign DONE1 = (state_q == StDone) && gnt_q;
    assign ERR0  = DONE0 && err_q;
    assign ERR1  = DONE1 && err_q;
    assign RDATA = rdata_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// Directed bench for eeprom_arb: a small engine model answers commands after a
// chosen number of WAIT cycles, and every observation is checked against hand values.
module tb_eeprom_arb;

    localparam int TO = 12;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0, REQ1, WE0, WE1;
    logic [10:0] ADDR0, ADDR1;
    logic [7:0]  WDATA0, WDATA1;
    logic        DONE0, DONE1, ERR0, ERR1;
    logic [7:0]  RDATA;
    logic        E_WR, E_RD;
    logic [10:0] E_ADDR;
    wire  [7:0]  E_DATA;
    logic        E_ACK;

    logic        eng_drive;
    logic [7:0]  eng_data;
    assign E_DATA = eng_drive ? eng_data : 8'hzz;

    eeprom_arb #(.TIMEOUT(TO)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .WE0    (WE0),
        .WE1    (WE1),
        .ADDR0  (ADDR0),
        .ADDR1  (ADDR1),
        .WDATA0 (WDATA0),
        .WDATA1 (WDATA1),
        .DONE0  (DONE0),
        .DONE1  (DONE1),
        .ERR0   (ERR0),
        .ERR1   (ERR1),
        .RDATA  (RDATA),
        .E_WR   (E_WR),
        .E_RD   (E_RD),
        .E_ADDR (E_ADDR),
        .E_DATA (E_DATA),
        .E_ACK  (E_ACK)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Results captured by the engine model for one transaction.
    int          t_iss, t_done;
    logic        r_wr, r_rd, r_both, r_cmd_last, r_cmd_done;
    logic        r_d0, r_d1, r_e0, r_e1;
    logic [10:0] r_addr;
    logic [7:0]  r_d_iss, r_d_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Caller has just raised the request(s) in an IDLE cycle. Answers with E_ACK
    // after k WAIT cycles when ack is set, otherwise waits for the timeout.
    task automatic engine(input int k, input bit ack, input logic [7:0] rval);
        int t0;
        int n;
        t0         = cyc;
        r_cmd_last = 1'b0;
        r_d_last   = 8'h00;
        n          = 0;
        do begin
            step();
            n++;
        end while (!(E_WR || E_RD) && n < 8);
        t_iss   = cyc - t0;
        r_wr    = E_WR;
        r_rd    = E_RD;
        r_addr  = E_ADDR;
        r_d_iss = E_DATA;
        r_both  = E_WR & E_RD;
        if (E_RD) begin
            eng_data  = rval;
            eng_drive = 1'b1;
        end
        if (ack) begin
            for (int i = 0; i <= k; i++) begin
                step();
                r_both = r_both | (E_WR & E_RD);
            end
            E_ACK = 1'b1;
        end
        n = 0;
        while (!(DONE0 || DONE1) && n < TO + 8) begin
            r_cmd_last = E_WR | E_RD;
            r_d_last   = E_DATA;
            step();
            E_ACK  = 1'b0;
            r_both = r_both | (E_WR & E_RD);
            n++;
        end
        t_done     = cyc - t0;
        r_d0       = DONE0;
        r_d1       = DONE1;
        r_e0       = ERR0;
        r_e1       = ERR1;
        r_cmd_done = E_WR | E_RD;
        eng_drive  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; E_ACK = 1'b0;
        eng_drive = 1'b1; eng_data = 8'h5A;
        step();
        step();

        // Reset values; engine drives the bus so a DUT driver would corrupt it.
        check("rst_e_wr", 32'(E_WR), 32'd0);
        check("rst_e_rd", 32'(E_RD), 32'd0);
        check("rst_done", 32'({DONE1, DONE0}), 32'd0);
        check("rst_err", 32'({ERR1, ERR0}), 32'd0);
        check("rst_rdata", 32'(RDATA), 32'h00);
        check("rst_e_addr", 32'(E_ADDR), 32'h000);
        check("rst_e_data_z", 32'(E_DATA), 32'h5A);
        RESET = 1'b0;
        eng_drive = 1'b0;

        // Stray acknowledge in IDLE does nothing.
        E_ACK = 1'b1;
        step();
        step();
        check("idle_ack_done", 32'({DONE1, DONE0}), 32'd0);
        check("idle_ack_cmd", 32'({E_WR, E_RD}), 32'd0);
        E_ACK = 1'b0;

        // Single write, acknowledged after 10 WAIT cycles.
        WE0 = 1'b1; ADDR0 = 11'h155; WDATA0 = 8'hA5; REQ0 = 1'b1;
        engine(10, 1'b1, 8'h00);
        check("wr_issue_lat", 32'(t_iss), 32'd1);
        check("wr_e_wr", 32'(r_wr), 32'd1);
        check("wr_e_rd", 32'(r_rd), 32'd0);
        check("wr_e_addr", 32'(r_addr), 32'h155);
        check("wr_e_data", 32'(r_d_iss), 32'hA5);
        check("wr_cmd_held", 32'(r_cmd_last), 32'd1);
        check("wr_done_lat", 32'(t_done), 32'd13);
        check("wr_done", 32'({r_d1, r_d0}), 32'b01);
        check("wr_err", 32'(r_e0), 32'd0);
        check("wr_cmd_drop", 32'(r_cmd_done), 32'd0);
        REQ0 = 1'b0;
        step();
        check("wr_done_pulse", 32'(DONE0), 32'd0);

        // Read; engine holds the bus throughout, so any DUT drive shows up.
        WE1 = 1'b0; ADDR1 = 11'h7FF; WDATA1 = 8'hC3;
        eng_data = 8'h3C; eng_drive = 1'b1; REQ1 = 1'b1;
        engine(3, 1'b1, 8'h3C);
        check("rd_e_rd", 32'(r_rd), 32'd1);
        check("rd_e_wr", 32'(r_wr), 32'd0);
        check("rd_e_addr", 32'(r_addr), 32'h7FF);
        check("rd_bus_issue", 32'(r_d_iss), 32'h3C);
        check("rd_bus_wait", 32'(r_d_last), 32'h3C);
        check("rd_done_lat", 32'(t_done), 32'd6);
        check("rd_done", 32'({r_d1, r_d0}), 32'b10);
        check("rd_err", 32'(r_e1), 32'd0);
        check("rd_rdata", 32'(RDATA), 32'h3C);
        REQ1 = 1'b0;
        step();

        // Contention after reset: grants alternate 0,1,0,1.
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        WE0 = 1'b1; ADDR0 = 11'h011; WDATA0 = 8'h5A;
        WE1 = 1'b0; ADDR1 = 11'h022;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            engine(0, 1'b1, 8'h11 + 8'(i));
            check("rr_done0", 32'(r_d0), 32'((i % 2) == 0));
            check("rr_done1", 32'(r_d1), 32'((i % 2) == 1));
            check("rr_addr", 32'(r_addr), ((i % 2) == 0) ? 32'h011 : 32'h022);
            check("rr_lat", 32'(t_done), 32'd3);
            check("rr_no_overlap", 32'(r_both), 32'd0);
            if (i == 2) check("rr_rdata_hold", 32'(RDATA), 32'h12);
            step();
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        step();

        // Acknowledge in the very cycle the counter expires: no error.
        WE1 = 1'b0; ADDR1 = 11'h400; REQ1 = 1'b1;
        engine(TO - 1, 1'b1, 8'h96);
        check("tie_lat", 32'(t_done), 32'(TO + 2));
        check("tie_done", 32'({r_d1, r_d0}), 32'b10);
        check("tie_err", 32'(r_e1), 32'd0);
        check("tie_rdata", 32'(RDATA), 32'h96);
        REQ1 = 1'b0;
        step();

        // No acknowledge: abort after TO WAIT cycles with error.
        WE0 = 1'b1; ADDR0 = 11'h2AB; WDATA0 = 8'h81; REQ0 = 1'b1;
        engine(0, 1'b0, 8'h00);
        check("to_lat", 32'(t_done), 32'(TO + 2));
        check("to_cmd_held", 32'(r_cmd_last), 32'd1);
        check("to_cmd_drop", 32'(r_cmd_done), 32'd0);
        check("to_done", 32'({r_d1, r_d0}), 32'b01);
        check("to_err", 32'(r_e0), 32'd1);
        check("to_rdata_hold", 32'(RDATA), 32'h96);
        REQ0 = 1'b0;
        step();
        check("to_err_pulse", 32'({ERR0, DONE0}), 32'd0);

        // Reset mid-WAIT: command drops, no DONE, pointer returns to requester 0.
        WE1 = 1'b1; ADDR1 = 11'h0AA; WDATA1 = 8'h77; REQ1 = 1'b1;
        step();
        step();
        step();
        check("mid_cmd_pre", 32'(E_WR), 32'd1);
        RESET = 1'b1;
        step();
        check("mid_cmd_drop", 32'({E_WR, E_RD}), 32'd0);
        check("mid_no_done", 32'({DONE1, DONE0}), 32'd0);
        check("mid_rdata", 32'(RDATA), 32'h00);
        RESET = 1'b0;
        REQ0 = 1'b1;
        engine(2, 1'b1, 8'h00);
        check("mid_next_gnt", 32'({r_d1, r_d0}), 32'b01);
        check("mid_next_addr", 32'(r_addr), 32'h2AB);
        check("mid_next_lat", 32'(t_done), 32'd5);
        check("mid_next_err", 32'(r_e0), 32'd0);
        REQ0 = 1'b0; REQ1 = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
